board_writer: RTL
=================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 Parameter COLS, default 10: playfield columns; legal range 1..16.
REQ-002 Parameter ROWS, default 20: playfield rows; legal range 2..32.
REQ-003 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port lock_valid, input, 1: request to commit the settled piece.
REQ-006 Ports x1..x4, input, 4 each: column of piece cells, 0 = left.
REQ-007 Ports y1..y4, input, 5 each: row of piece cells, 0 = top.
REQ-008 Port block_type, input, 3: cell code to store; 0 = empty.
REQ-009 Port busy, output, 1: a commit is in progress, from accept through DONE.
REQ-010 Port rd_x, input, 4, and rd_y, input, 5: renderer read address.
REQ-011 Port rd_type, output, 3: stored code at (rd_x, rd_y), combinational.
REQ-012 Port done, output, 1: one-cycle pulse when a commit completes.
REQ-013 Port lines_cleared, output, 3: rows removed by the last commit.
REQ-014 Port lines_total, output, 14: running cleared-row count for the score digits.
REQ-015 Port game_over, output, 1: sticky overflow flag.

Function
REQ-016 Storage: ROWS x COLS cells of 3 bits, register based; rd_type returns 0 for rd_x >= COLS or rd_y >= ROWS.
REQ-017 Accept: the FSM is in IDLE, lock_valid = 1 and game_over = 0 -> latch x1..x4, y1..y4, block_type; next state WRITE. Otherwise lock_valid is ignored.
REQ-018 States: IDLE, WRITE, SCAN, DONE; encoding is free.
REQ-019 WRITE lasts 1 cycle: write block_type to all 4 latched cells at once. A cell with x >= COLS or y >= ROWS is dropped silently. Duplicate coordinates write the same value.
REQ-020 WRITE: if any in-range target cell is already non-zero, set game_over. The write still occurs.
REQ-021 Entering SCAN: row pointer r = ROWS-1 and the cleared counter = 0.
REQ-022 SCAN, row r full (all COLS cells non-zero): in the same cycle, row k takes row k-1 for k = r down to 1, and row 0 is zeroed. Counter +1. r holds, so the row is re-examined.
REQ-023 SCAN, row r not full: if r > 0, decrement r. If r = 0, go to DONE.
REQ-024 SCAN therefore takes ROWS + L cycles, where L is the number of rows cleared.
REQ-025 DONE lasts 1 cycle:
- done = 1;
- lines_cleared <= L;
- lines_total <= lines_total + L, saturating at 9999;
- game_over is set if any row-0 cell is non-zero;
- next state IDLE.
REQ-026 lines_cleared holds its value until the next DONE.
REQ-027 busy = 1 in WRITE, SCAN and DONE; busy = 0 in IDLE.
REQ-028 Total latency: accept edge -> done pulse = ROWS + L + 2 cycles. A new accept is possible on the cycle after DONE.
REQ-029 Inputs x/y/block_type are don't-care after accept; changes during busy have no effect.
REQ-030 game_over, once set, blocks all further accepts until reset. rd_type stays readable.
REQ-031 rd_type reflects the board registers at all times, including mid-SCAN.

Reset
REQ-032 resetn = 0 immediately sets:
- all cells = 0;
- state = IDLE, busy = 0, done = 0;
- lines_cleared = 0, lines_total = 0, game_over = 0.
REQ-033 Reset asserted mid-commit aborts the commit with no partial completion. The first accept is possible on the first rising edge after resetn = 1.

Verification
REQ-034 Empty board; commit O-piece type 2 at (4,18),(5,18),(4,19),(5,19) -> done 22 cycles after accept; lines_cleared = 0; rd_type(4,19) = 2; rd_type(3,19) = 0.
REQ-035 Row 19 prefilled at x = 0..5 and row 18 at x = 0..9 with type 3; commit I-piece type 1 at (6..9,19) -> lines_cleared = 2, latency 24, lines_total = 2. Rows 18 and 19 read 0.
REQ-036 Row 0 full at reset-free start plus a commit that fills row 19 -> row 19 cleared and row 0 shifted to row 1; game_over = 0 if row 0 is empty at DONE.
REQ-037 Commit targeting an occupied cell -> game_over = 1 at WRITE. The next lock_valid gets busy = 0 and no done. Out-of-range cell (x = 12) is not written.
REQ-038 resetn pulsed low during SCAN -> busy = 0 and all rd_type = 0 immediately. lock_valid on the first edge after release is accepted.
REQ-039 lines_total preloaded to 9998 via repeated commits; commit clearing 4 lines -> lines_total = 9999, lines_cleared = 4.

Source files
------------

// File: rtl/board_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_writer_if
// Brief    : Commit request, renderer read port and status of board_writer.
// Revision : 1.0
// ============================================================================
interface board_writer_if;
    logic        lock_valid;
    logic [3:0]  x1, x2, x3, x4;
    logic [4:0]  y1, y2, y3, y4;
    logic [2:0]  block_type;
    logic        busy;
    logic [3:0]  rd_x;
    logic [4:0]  rd_y;
    logic [2:0]  rd_type;
    logic        done;
    logic [2:0]  lines_cleared;
    logic [13:0] lines_total;
    logic        game_over;

    modport master (
        output lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, block_type, rd_x, rd_y,
        input  busy, rd_type, done, lines_cleared, lines_total, game_over
    );

    modport slave (
        input  lock_valid, x1, x2, x3, x4, y1, y2, y3, y4, block_type, rd_x, rd_y,
        output busy, rd_type, done, lines_cleared, lines_total, game_over
    );
endinterface
`default_nettype wire

// File: rtl/board_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_writer
// Brief    : Commits a settled piece into the playfield and removes full rows.
// Revision : 1.0
// ============================================================================
module board_writer #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  wire            clk,
    input  wire            resetn,
    board_writer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [14:0] c_total_max = 15'd9999;

    state_t      r_state;
    logic [2:0]  r_board [ROWS][COLS];
    logic [3:0]  r_x [4];
    logic [4:0]  r_y [4];
    logic [2:0]  r_type;
    logic [4:0]  r_row;
    logic [2:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic        r_game_over;
    logic [2:0]  r_lines_cleared;
    logic [13:0] r_lines_total;

    logic [COLS-1:0]      w_nz  [ROWS];
    logic [COLS-1:0]      w_hit [ROWS];
    logic [ROWS-1:0]      w_row_full;
    logic [ROWS*COLS-1:0] w_clash;
    logic                 w_cur_full;
    logic [2:0]           w_rd_type;
    logic [14:0]          w_total_sum;

    // Out-of-range piece cells simply never match any generated cell.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [4:0] c_row = 5'(r);
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam logic [3:0] c_col = 4'(c);
            assign w_nz[r][c]  = |r_board[r][c];
            assign w_hit[r][c] = (r_x[0] == c_col && r_y[0] == c_row) ||
                                 (r_x[1] == c_col && r_y[1] == c_row) ||
                                 (r_x[2] == c_col && r_y[2] == c_row) ||
                                 (r_x[3] == c_col && r_y[3] == c_row);
            assign w_clash[r*COLS+c] = w_hit[r][c] & w_nz[r][c];
        end
        assign w_row_full[r] = &w_nz[r];
    end

    always_comb begin
        w_cur_full = 1'b0;
        w_rd_type  = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_row == 5'(r)) begin
                w_cur_full = w_row_full[r];
            end
            for (int c = 0; c < COLS; c++) begin
                if (bus.rd_y == 5'(r) && bus.rd_x == 4'(c)) begin
                    w_rd_type = r_board[r][c];
                end
            end
        end
    end

    assign w_total_sum = {1'b0, r_lines_total} + 15'(r_count);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_type          <= 3'd0;
            r_row           <= 5'd0;
            r_count         <= 3'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_game_over     <= 1'b0;
            r_lines_cleared <= 3'd0;
            r_lines_total   <= 14'd0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= 4'd0;
                r_y[i] <= 5'd0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_board[r][c] <= 3'd0;
                end
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.lock_valid && !r_game_over) begin
                        r_x[0]  <= bus.x1;
                        r_x[1]  <= bus.x2;
                        r_x[2]  <= bus.x3;
                        r_x[3]  <= bus.x4;
                        r_y[0]  <= bus.y1;
                        r_y[1]  <= bus.y2;
                        r_y[2]  <= bus.y3;
                        r_y[3]  <= bus.y4;
                        r_type  <= bus.block_type;
                        r_busy  <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (w_hit[r][c]) begin
                                r_board[r][c] <= r_type;
                            end
                        end
                    end
                    if (|w_clash) begin
                        r_game_over <= 1'b1;
                    end
                    r_row   <= 5'(ROWS - 1);
                    r_count <= 3'd0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    // A cleared row keeps the pointer so the row shifted in is re-examined.
                    if (w_cur_full) begin
                        for (int k = 1; k < ROWS; k++) begin
                            if (5'(k) <= r_row) begin
                                r_board[k] <= r_board[k-1];
                            end
                        end
                        for (int c = 0; c < COLS; c++) begin
                            r_board[0][c] <= 3'd0;
                        end
                        r_count <= r_count + 3'd1;
                    end else if (r_row != 5'd0) begin
                        r_row <= r_row - 5'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_lines_cleared <= r_count;
                    r_lines_total   <= (w_total_sum >= c_total_max) ? c_total_max[13:0]
                                                                    : w_total_sum[13:0];
                    if (|w_nz[0]) begin
                        r_game_over <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.rd_type       = w_rd_type;
    assign bus.lines_cleared = r_lines_cleared;
    assign bus.lines_total   = r_lines_total;
    assign bus.game_over     = r_game_over;

endmodule
`default_nettype wire
